// File: rtl/pipeline_debug_ctrl_pkg.sv
// Shared encodings for the pipeline debug controller: FSM states, UART
// command bytes and the instruction word that terminates a load.
package pipeline_debug_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_QUIT  = 8'h51;  // 'Q'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Address width for a memory of 'depth' words (at least one bit).
  function automatic int clogb2(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// Bundle between the debug controller, the UART receiver and the pipeline.
// master: the controller itself; slave: the UART/pipeline side.
interface pipeline_debug_ctrl_if #(
  parameter int NB_INSTR           = 32,
  parameter int LOG2_N_INSMEM_ADDR = 5,
  parameter int NB_CNT             = 32
);
  logic [7:0]                    i_rx_data;
  logic                          i_rx_valid;
  logic                          i_halt;
  logic                          o_pipe_valid;
  logic                          o_pipe_reset;
  logic                          o_imem_we;
  logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr;
  logic [NB_INSTR-1:0]           o_imem_data;
  logic [2:0]                    o_state;
  logic [NB_CNT-1:0]             o_cycle_count;
  logic                          o_done;

  modport master (
    input  i_rx_data, i_rx_valid, i_halt,
    output o_pipe_valid, o_pipe_reset, o_imem_we, o_imem_addr, o_imem_data,
           o_state, o_cycle_count, o_done
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_halt,
    input  o_pipe_valid, o_pipe_reset, o_imem_we, o_imem_addr, o_imem_data,
           o_state, o_cycle_count, o_done
  );
endinterface

// File: rtl/pipeline_debug_ctrl_imem_word_assembler.sv
// Packs UART bytes (MSB first) into instruction words and issues one
// registered instruction-memory write per completed word.
module imem_word_assembler
  import pipeline_debug_pkg::*;
#(
  parameter int                  NB_INSTR           = 32,
  parameter int                  N_ADDR             = 32,
  parameter int                  LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
  parameter logic [NB_INSTR-1:0] HALT_WORD          = NB_INSTR'(HALT_WORD_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,     // clear counters for a new load
  input  logic                          en,        // bytes are data (LOAD state)
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          we,
  output logic [LOG2_N_INSMEM_ADDR-1:0] addr,
  output logic [NB_INSTR-1:0]           data,
  output logic                          load_end   // this byte completes the final word
);
  localparam int NB_BYTES = NB_INSTR / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [NB_BCNT-1:0]            byte_cnt;
  logic [LOG2_N_INSMEM_ADDR-1:0] addr_cnt;
  logic [NB_INSTR-9:0]           shift_p0;
  logic [NB_INSTR-1:0]           word_next;
  logic                          byte_acc;
  logic                          last_byte;

  assign byte_acc  = en && rx_valid;
  assign word_next = {shift_p0, rx_data};
  assign last_byte = byte_acc && (byte_cnt == NB_BCNT'(NB_BYTES - 1));
  // Decided while the last byte is on the bus so the FSM leaves LOAD in the
  // same edge as the write is registered and the next byte is a command.
  assign load_end  = last_byte &&
                     ((word_next == HALT_WORD) ||
                      (addr_cnt == LOG2_N_INSMEM_ADDR'(N_ADDR - 1)));

  // Byte shift register; stale bits are always overwritten before use.
  always_ff @(posedge clk) begin
    if (byte_acc) shift_p0 <= word_next[NB_INSTR-9:0];
  end

  // Byte and address counters; a reset mid-word discards the partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      addr_cnt <= '0;
    end else if (start) begin
      byte_cnt <= '0;
      addr_cnt <= '0;
    end else if (byte_acc) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      if (last_byte) addr_cnt <= addr_cnt + 1'b1;
    end
  end

  // ---- stage p1: registered memory write port ----
  // Write strobe, address and data; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      we <= last_byte;
      if (last_byte) begin
        addr <= addr_cnt;
        data <= word_next;
      end
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencing controller for the MIPS pipeline: decodes UART commands,
// loads instruction memory, gates the pipeline enable for run/step and
// counts executed cycles.
module pipeline_debug_ctrl
  import pipeline_debug_pkg::*;
#(
  parameter int                  NB_INSTR           = 32,
  parameter int                  N_ADDR             = 32,
  parameter int                  LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
  parameter int                  NB_CNT             = 32,
  parameter logic [NB_INSTR-1:0] HALT_WORD          = NB_INSTR'(HALT_WORD_DEFAULT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  pipeline_debug_ctrl_if.master bus
);
  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              step_p1;
  logic              pipe_reset_p1;
  logic [NB_CNT-1:0] cycle_cnt;
  logic              pipe_valid;
  logic              rx;
  logic              halt;
  logic              load_start;
  logic              load_end;
  logic              clear_cmd;
  logic              step_req;
  logic              imem_we;

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rx         = bus.i_rx_valid;
  assign halt       = bus.i_halt;
  assign load_start = (state == ST_IDLE) && rx && (bus.i_rx_data == CMD_LOAD);
  assign clear_cmd  = ((state == ST_IDLE) || (state == ST_DONE)) && rx &&
                      (bus.i_rx_data == CMD_CLEAR);
  // Halt wins over a simultaneous 'N'.
  assign step_req   = (state == ST_STEP) && rx && !halt &&
                      (bus.i_rx_data == CMD_NEXT);

  imem_word_assembler #(
    .NB_INSTR          (NB_INSTR),
    .N_ADDR            (N_ADDR),
    .LOG2_N_INSMEM_ADDR(LOG2_N_INSMEM_ADDR),
    .HALT_WORD         (HALT_WORD)
  ) u_asm (
    .clk     (i_clock),
    .rst     (i_reset),
    .start   (load_start),
    .en      (state == ST_LOAD),
    .rx_valid(rx),
    .rx_data (bus.i_rx_data),
    .we      (imem_we),
    .addr    (bus.o_imem_addr),
    .data    (bus.o_imem_data),
    .load_end(load_end)
  );

  // Next-state decode of the command stream.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx) begin
          case (bus.i_rx_data)
            CMD_LOAD: state_next = ST_LOAD;
            CMD_RUN:  state_next = ST_RUN;
            CMD_STEP: state_next = ST_STEP;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: if (load_end) state_next = ST_IDLE;
      ST_RUN:  if (halt) state_next = ST_DONE;
      ST_STEP: begin
        if (halt) state_next = ST_DONE;
        else if (rx && (bus.i_rx_data == CMD_QUIT)) state_next = ST_IDLE;
      end
      ST_DONE: if (clear_cmd) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Halt gates RUN combinationally; enable never overlaps reset or a write.
  assign pipe_valid = (((state == ST_RUN) && !halt) || step_p1) &&
                      !pipe_reset_p1 && !imem_we;

  // ---- stage p1: FSM state, step pulse and pipeline reset pulse ----
  // Reset pulse register comes out of reset high to give one pulse after release.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      step_p1       <= 1'b0;
      pipe_reset_p1 <= 1'b1;
    end else begin
      state         <= state_next;
      step_p1       <= step_req;
      pipe_reset_p1 <= clear_cmd;
    end
  end

  // Saturating count of enabled pipeline cycles, cleared by 'C'.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)         cycle_cnt <= '0;
    else if (clear_cmd)  cycle_cnt <= '0;
    else if (pipe_valid) cycle_cnt <= sat_inc(cycle_cnt);
  end

  assign bus.o_pipe_valid  = pipe_valid;
  assign bus.o_pipe_reset  = pipe_reset_p1;
  assign bus.o_imem_we     = imem_we;
  assign bus.o_state       = state;
  assign bus.o_cycle_count = cycle_cnt;
  assign bus.o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Scenario bench for pipeline_debug_ctrl: expected memory writes are queued
// when bytes are driven and popped when the DUT strobes o_imem_we.
module tb_pipeline_debug_ctrl;
  localparam int NB_INSTR = 32;
  localparam int N_ADDR   = 32;
  localparam int AW       = 5;
  localparam int NB_CNT   = 4;   // narrow counter so saturation is reachable

  typedef struct {
    logic [AW-1:0]       addr;
    logic [NB_INSTR-1:0] data;
  } wr_t;

  logic tb_clock_i = 1'b0;
  logic tb_reset_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   vld_cycles = 0;
  int   vld_rises = 0;
  logic prev_vld = 1'b0;
  wr_t  exp_q[$];

  always #5 tb_clock_i = ~tb_clock_i;

  pipeline_debug_ctrl_if #(.NB_INSTR(NB_INSTR), .LOG2_N_INSMEM_ADDR(AW), .NB_CNT(NB_CNT)) bus ();

  pipeline_debug_ctrl #(
    .NB_INSTR(NB_INSTR), .N_ADDR(N_ADDR), .LOG2_N_INSMEM_ADDR(AW), .NB_CNT(NB_CNT)
  ) dut (
    .i_clock(tb_clock_i),
    .i_reset(tb_reset_i),
    .bus    (bus)
  );

  // One clock: sample mid-cycle (scoreboard + enable bookkeeping), return at posedge+1.
  task automatic tick();
    wr_t e;
    @(negedge tb_clock_i);
    if (!tb_reset_i) begin
      if (bus.o_imem_we) begin
        writes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL imem_write_unexpected: got addr %0d data %h, required no write",
                   bus.o_imem_addr, bus.o_imem_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_imem_addr !== e.addr || bus.o_imem_data !== e.data) begin
            errors++;
            $display("FAIL imem_write: got addr %0d data %h, required addr %0d data %h",
                     bus.o_imem_addr, bus.o_imem_data, e.addr, e.data);
          end
        end
      end
      if (bus.o_pipe_valid) begin
        vld_cycles++;
        if (!prev_vld) vld_rises++;
        checks++;
        if (bus.o_pipe_reset || bus.o_imem_we) begin
          errors++;
          $display("FAIL valid_exclusive: got valid=1 reset=%b we=%b, required reset=0 we=0",
                   bus.o_pipe_reset, bus.o_imem_we);
        end
      end
      prev_vld = bus.o_pipe_valid;
    end
    @(posedge tb_clock_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.o_state !== 3'd0 || bus.o_imem_we !== 1'b0 || bus.o_pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got state %0d we %b valid %b, required 0 0 0",
               bus.o_state, bus.o_imem_we, bus.o_pipe_valid);
    end
    @(posedge tb_clock_i);
    #1;
    tb_reset_i = 1'b0;
    #1;
    checks++;
    if (bus.o_pipe_reset !== 1'b1 || bus.o_pipe_valid !== 1'b0 || bus.o_imem_we !== 1'b0 ||
        bus.o_imem_addr !== '0 || bus.o_imem_data !== '0 || bus.o_state !== 3'd0 ||
        bus.o_cycle_count !== '0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got prst %b valid %b we %b addr %0d data %h state %0d cnt %0d done %b, required 1 0 0 0 0 0 0 0",
               bus.o_pipe_reset, bus.o_pipe_valid, bus.o_imem_we, bus.o_imem_addr,
               bus.o_imem_data, bus.o_state, bus.o_cycle_count, bus.o_done);
    end
    tick();
    checks++;
    if (bus.o_pipe_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_len: got pipe_reset %b, required 0", bus.o_pipe_reset);
    end
  endtask

  task automatic test_load_halt();
    int w0;
    w0 = writes;
    send_byte(8'h4C);
    checks++;
    if (bus.o_state !== 3'd1) begin
      errors++;
      $display("FAIL load_enter: got state %0d, required 1", bus.o_state);
    end
    expect_wr(5'd0, 32'h2001_0005);
    send_word(32'h2001_0005);
    expect_wr(5'd1, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    checks++;
    if (bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL load_halt_exit: got state %0d, required 0", bus.o_state);
    end
    tick();
    checks++;
    if (writes - w0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_write_count: got %0d writes, %0d pending, required 2 writes 0 pending",
               writes - w0, exp_q.size());
    end
  endtask

  task automatic test_run();
    int v0;
    v0 = vld_cycles;
    send_byte(8'h52);
    checks++;
    if (bus.o_state !== 3'd2) begin
      errors++;
      $display("FAIL run_enter: got state %0d, required 2", bus.o_state);
    end
    repeat (10) tick();
    bus.i_halt = 1'b1;
    #1;
    checks++;
    if (bus.o_pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_halt_gate: got valid %b, required 0", bus.o_pipe_valid);
    end
    tick();
    bus.i_halt = 1'b0;
    checks++;
    if (vld_cycles - v0 != 10 || bus.o_cycle_count !== 4'd10 || bus.o_state !== 3'd4 ||
        bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL run_halt: got valid cycles %0d cnt %0d state %0d done %b, required 10 10 4 1",
               vld_cycles - v0, bus.o_cycle_count, bus.o_state, bus.o_done);
    end
    send_byte(8'h4E);
    tick();
    checks++;
    if (bus.o_state !== 3'd4 || bus.o_pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore: got state %0d valid %b, required 4 0", bus.o_state, bus.o_pipe_valid);
    end
    send_byte(8'h43);
    checks++;
    if (bus.o_pipe_reset !== 1'b1 || bus.o_cycle_count !== '0 || bus.o_state !== 3'd0 ||
        bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: got prst %b cnt %0d state %0d done %b, required 1 0 0 0",
               bus.o_pipe_reset, bus.o_cycle_count, bus.o_state, bus.o_done);
    end
    tick();
  endtask

  task automatic test_saturate();
    send_byte(8'h52);
    repeat (20) tick();
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    checks++;
    if (bus.o_cycle_count !== 4'hF || bus.o_state !== 3'd4) begin
      errors++;
      $display("FAIL count_saturate: got cnt %0d state %0d, required 15 4",
               bus.o_cycle_count, bus.o_state);
    end
    send_byte(8'h43);
    tick();
  endtask

  task automatic test_step();
    int v0;
    int r0;
    send_byte(8'h43);
    send_byte(8'h53);
    v0 = vld_cycles;
    r0 = vld_rises;
    for (int n = 0; n < 3; n++) begin
      send_byte(8'h4E);
      checks++;
      if (bus.o_pipe_valid !== 1'b1) begin
        errors++;
        $display("FAIL step_pulse_%0d: got valid %b, required 1", n, bus.o_pipe_valid);
      end
      tick();
      checks++;
      if (bus.o_pipe_valid !== 1'b0) begin
        errors++;
        $display("FAIL step_pulse_end_%0d: got valid %b, required 0", n, bus.o_pipe_valid);
      end
    end
    send_byte(8'h51);
    checks++;
    if (vld_cycles - v0 != 3 || vld_rises - r0 != 3 || bus.o_cycle_count !== 4'd3 ||
        bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL step_seq: got cycles %0d pulses %0d cnt %0d state %0d, required 3 3 3 0",
               vld_cycles - v0, vld_rises - r0, bus.o_cycle_count, bus.o_state);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    int r0;
    send_byte(8'h43);
    send_byte(8'h53);
    v0 = vld_cycles;
    r0 = vld_rises;
    send_byte(8'h4E);
    send_byte(8'h4E);
    tick();
    send_byte(8'h51);
    checks++;
    if (vld_cycles - v0 != 2 || vld_rises - r0 != 1 || bus.o_cycle_count !== 4'd2 ||
        bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL back_to_back_step: got cycles %0d rises %0d cnt %0d state %0d, required 2 1 2 0",
               vld_cycles - v0, vld_rises - r0, bus.o_cycle_count, bus.o_state);
    end
  endtask

  task automatic test_step_halt();
    int v0;
    send_byte(8'h53);
    v0 = vld_cycles;
    bus.i_halt     = 1'b1;
    bus.i_rx_data  = 8'h4E;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    tick();
    bus.i_halt = 1'b0;
    checks++;
    if (vld_cycles - v0 != 0 || bus.o_state !== 3'd4) begin
      errors++;
      $display("FAIL step_halt_priority: got valid cycles %0d state %0d, required 0 4",
               vld_cycles - v0, bus.o_state);
    end
    send_byte(8'h43);
    checks++;
    if (bus.o_pipe_reset !== 1'b1 || bus.o_cycle_count !== '0 || bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL step_halt_clear: got prst %b cnt %0d state %0d, required 1 0 0",
               bus.o_pipe_reset, bus.o_cycle_count, bus.o_state);
    end
    tick();
  endtask

  task automatic test_load_reset();
    int w0;
    w0 = writes;
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    #2;
    tb_reset_i = 1'b1;
    #1;
    checks++;
    if (bus.o_state !== 3'd0 || bus.o_imem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state %0d we %b, required 0 0", bus.o_state, bus.o_imem_we);
    end
    @(posedge tb_clock_i);
    @(posedge tb_clock_i);
    #1;
    tb_reset_i = 1'b0;
    checks++;
    if (bus.o_pipe_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pulse: got pipe_reset %b, required 1", bus.o_pipe_reset);
    end
    tick();
    send_byte(8'h4C);
    expect_wr(5'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    tick();
    checks++;
    if (writes - w0 != 1 || exp_q.size() != 0 || bus.o_state !== 3'd1) begin
      errors++;
      $display("FAIL reload_after_reset: got %0d writes %0d pending state %0d, required 1 0 1",
               writes - w0, exp_q.size(), bus.o_state);
    end
    expect_wr(5'd1, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    tick();
  endtask

  task automatic test_load_wrap();
    int w0;
    w0 = writes;
    send_byte(8'h4C);
    for (int i = 0; i < N_ADDR; i++) begin
      expect_wr(AW'(i), 32'h0100_0000 + 32'(i));
      send_word(32'h0100_0000 + 32'(i));
    end
    checks++;
    if (bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL wrap_exit: got state %0d, required 0", bus.o_state);
    end
    tick();
    send_byte(8'hAA);
    tick();
    checks++;
    if (writes - w0 != N_ADDR || exp_q.size() != 0 || bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL wrap_writes: got %0d writes %0d pending state %0d, required 32 0 0",
               writes - w0, exp_q.size(), bus.o_state);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_halt     = 1'b0;
    repeat (2) @(posedge tb_clock_i);
    test_reset();
    test_load_halt();
    test_run();
    test_saturate();
    test_step();
    test_back_to_back();
    test_step_halt();
    test_load_reset();
    test_load_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
